// File: rtl/dawn_pkg.sv
// Shared Y86-64 core definitions: status encoding and the "no register" code.
package dawn_pkg;

    typedef enum logic [1:0] {
        AOK = 2'd0,
        HLT = 2'd1,
        ADR = 2'd2,
        INS = 2'd3
    } stat_t;

    localparam int unsigned RADDR_W_DFLT = 4;
    localparam logic [RADDR_W_DFLT-1:0] REG_NONE = {RADDR_W_DFLT{1'b1}};

endpackage

// File: rtl/wb_stat_enc.sv
// Priority encoder: instruction error/halt flags of the M slot to a stat_t.
module wb_stat_enc
    import dawn_pkg::*;
(
    input  logic  valid_i,
    input  logic  hlt_i,
    input  logic  instr_valid_i,
    input  logic  imem_error_i,
    input  logic  dmem_error_i,
    output stat_t stat_o
);

    always_comb begin
        stat_o = AOK;
        if (!valid_i) begin
            stat_o = AOK;
        end else if (imem_error_i) begin
            stat_o = ADR;
        end else if (!instr_valid_i) begin
            stat_o = INS;
        end else if (hlt_i) begin
            stat_o = HLT;
        end else if (dmem_error_i) begin
            stat_o = ADR;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Y86-64 writeback stage: W pipeline register, register-file write ports, sticky status.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage
    import dawn_pkg::stat_t, dawn_pkg::AOK;
#(
    parameter int unsigned        DATA_W   = 64,
    parameter int unsigned        RADDR_W  = 4,
    parameter logic [RADDR_W-1:0] REG_NONE = {RADDR_W{1'b1}}
`ifdef WB_RETIRE_CNT_EN
    ,parameter int unsigned       CNT_W    = 32
`endif
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               m_valid_i,
    input  logic [DATA_W-1:0]  m_valE_i,
    input  logic [DATA_W-1:0]  m_valM_i,
    input  logic [RADDR_W-1:0] m_dstE_i,
    input  logic [RADDR_W-1:0] m_dstM_i,
    input  logic               m_hlt_i,
    input  logic               m_instr_valid_i,
    input  logic               m_imem_error_i,
    input  logic               m_dmem_error_i,
    input  logic               w_stall_i,
    input  logic               w_bubble_i,
    output logic               rf_weE_o,
    output logic [RADDR_W-1:0] rf_dstE_o,
    output logic [DATA_W-1:0]  rf_valE_o,
    output logic               rf_weM_o,
    output logic [RADDR_W-1:0] rf_dstM_o,
    output logic [DATA_W-1:0]  rf_valM_o,
    output logic [1:0]         w_stat_o,
    output logic [1:0]         cpu_stat_o,
    output logic               halted_o
`ifdef WB_RETIRE_CNT_EN
    ,output logic [CNT_W-1:0]  retire_cnt_o
`endif
);

    typedef enum logic [0:0] {StRun, StStop} state_t;

    stat_t m_stat;

    logic               w_valid_q, w_valid_d;
    logic [DATA_W-1:0]  w_val_e_q, w_val_e_d;
    logic [DATA_W-1:0]  w_val_m_q, w_val_m_d;
    logic [RADDR_W-1:0] w_dst_e_q, w_dst_e_d;
    logic [RADDR_W-1:0] w_dst_m_q, w_dst_m_d;
    stat_t              w_stat_q, w_stat_d;
    state_t             state_q, state_d;
    stat_t              cpu_stat_q, cpu_stat_d;
    logic               w_ok;

    wb_stat_enc u_stat_enc (
        .valid_i       (m_valid_i),
        .hlt_i         (m_hlt_i),
        .instr_valid_i (m_instr_valid_i),
        .imem_error_i  (m_imem_error_i),
        .dmem_error_i  (m_dmem_error_i),
        .stat_o        (m_stat)
    );

    always_comb begin
        w_valid_d = w_valid_q;
        w_val_e_d = w_val_e_q;
        w_val_m_d = w_val_m_q;
        w_dst_e_d = w_dst_e_q;
        w_dst_m_d = w_dst_m_q;
        w_stat_d  = w_stat_q;
        if (w_stall_i) begin
            // hold
        end else if (w_bubble_i || !m_valid_i) begin
            w_valid_d = 1'b0;
            w_val_e_d = '0;
            w_val_m_d = '0;
            w_dst_e_d = REG_NONE;
            w_dst_m_d = REG_NONE;
            w_stat_d  = AOK;
        end else begin
            w_valid_d = 1'b1;
            w_val_e_d = m_valE_i;
            w_val_m_d = m_valM_i;
            w_dst_e_d = m_dstE_i;
            w_dst_m_d = m_dstM_i;
            w_stat_d  = m_stat;
        end
    end

    // Reset clears W to zero (invalid) so every rf_* output reads 0 during reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            w_valid_q  <= 1'b0;
            w_val_e_q  <= '0;
            w_val_m_q  <= '0;
            w_dst_e_q  <= '0;
            w_dst_m_q  <= '0;
            w_stat_q   <= AOK;
            state_q    <= StRun;
            cpu_stat_q <= AOK;
        end else begin
            w_valid_q  <= w_valid_d;
            w_val_e_q  <= w_val_e_d;
            w_val_m_q  <= w_val_m_d;
            w_dst_e_q  <= w_dst_e_d;
            w_dst_m_q  <= w_dst_m_d;
            w_stat_q   <= w_stat_d;
            state_q    <= state_d;
            cpu_stat_q <= cpu_stat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cpu_stat_d = cpu_stat_q;
        unique case (state_q)
            StRun: begin
                if (w_valid_q && (w_stat_q != AOK) && !w_stall_i) begin
                    state_d    = StStop;
                    cpu_stat_d = w_stat_q;
                end
            end
            StStop: begin
                state_d = StStop;
            end
            default: state_d = StRun;
        endcase
    end

    assign halted_o   = (state_q == StStop);
    assign w_ok       = w_valid_q && (w_stat_q == AOK) && !halted_o;
    assign rf_weE_o   = w_ok && (w_dst_e_q != REG_NONE);
    assign rf_weM_o   = w_ok && (w_dst_m_q != REG_NONE);
    assign rf_dstE_o  = w_dst_e_q;
    assign rf_valE_o  = w_val_e_q;
    assign rf_dstM_o  = w_dst_m_q;
    assign rf_valM_o  = w_val_m_q;
    assign w_stat_o   = w_stat_q;
    assign cpu_stat_o = cpu_stat_q;

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            retire_cnt_q <= '0;
        end else if (w_ok && !w_stall_i) begin
            retire_cnt_q <= retire_cnt_q + CNT_W'(1);
        end
    end

    assign retire_cnt_o = retire_cnt_q;
`endif

endmodule

// File: doc/wb_stage.md
# wb_stage

Pipelined writeback stage for the Y86-64 core. A W pipeline register captures memory-stage results, then drives the two register-file write ports (E and M). It also supplies the W-stage forwarding values and resolves the per-instruction status code into a sticky processor status that stops the core. Successor to the combinational writeback: width- and register-address-parametrised, with stall/bubble control, status priority encoding and halt latching.

## Interface
- DATA_W, 64, datapath width of valE/valM
- RADDR_W, 4, register-file address width
- REG_NONE, {RADDR_W{1'b1}}, destination code meaning "no write"
- CNT_W, 32, retire counter width (used only with WB_RETIRE_CNT_EN)

Ports:
- clk_i  in  1  core clock
- rst_n_i  in  1  reset, asynchronous, active-low
- m_valid_i  in  1  M stage holds a real instruction
- m_valE_i  in  DATA_W  ALU result
- m_valM_i  in  DATA_W  memory read data
- m_dstE_i  in  RADDR_W  destination for valE
- m_dstM_i  in  RADDR_W  destination for valM
- m_hlt_i  in  1  instruction is halt
- m_instr_valid_i  in  1  opcode legal
- m_imem_error_i  in  1  fetch address error
- m_dmem_error_i  in  1  data memory address error
- w_stall_i  in  1  hold W register
- w_bubble_i  in  1  load NOP into W
- rf_weE_o  out  1  write enable, port E
- rf_dstE_o  out  RADDR_W  port E address
- rf_valE_o  out  DATA_W  port E data
- rf_weM_o  out  1  write enable, port M
- rf_dstM_o  out  RADDR_W  port M address
- rf_valM_o  out  DATA_W  port M data
- w_stat_o  out  2  status of instruction in W
- cpu_stat_o  out  2  sticky processor status
- halted_o  out  1  cpu_stat_o != AOK
- retire_cnt_o  out  CNT_W  retired instruction count (WB_RETIRE_CNT_EN only)

## Operation
- Status encoding: AOK=0, HLT=1, ADR=2, INS=3.
- Priority at M→W capture: m_imem_error_i → ADR; else !m_instr_valid_i → INS; else m_hlt_i → HLT; else m_dmem_error_i → ADR; else AOK. A non-valid slot (bubble) is AOK with both destinations REG_NONE.
- W register fields: valid, valE, valM, dstE, dstM, stat.
- Per edge: w_stall_i=1 → hold; else w_bubble_i=1 → load NOP; else load M inputs. Stall wins over bubble.
- rf_weE_o = valid & dstE!=REG_NONE & stat==AOK & !halted_o; same rule for rf_weM_o using dstM. rf_val*_o and rf_dst*_o always reflect the W contents. valM is driven on port M, never valE.
- Sticky FSM with states RUN and STOP. RUN→STOP on an edge where W holds a valid non-AOK stat and w_stall_i=0. cpu_stat_o captures that stat. STOP exits only on reset.
- Both destinations equal and both writes enabled: port M has priority in the register file. This block drives both unchanged.

## Timing
- Latency is 1 cycle: M inputs appear on the rf_* outputs after the next clk_i rising edge. Write enables are combinational from W state.
- Reset (async assert, sync-free deassert): W = NOP, w_stat_o=AOK, cpu_stat_o=AOK, halted_o=0, all rf_* outputs 0, retire_cnt_o=0.
- A stalled W holding a non-AOK instruction drives w_stat_o immediately. cpu_stat_o latches one edge after the stall releases.
- Once halted_o=1, no write enable asserts regardless of W contents.
- Reset mid-stream discards W contents. No write occurs in the reset cycle.

## Configuration
- WB_RETIRE_CNT_EN defined: retire_cnt_o present. It increments by 1 on each edge where W is valid, stat==AOK, halted_o=0 and w_stall_i=0, and wraps modulo 2^CNT_W.
- Not defined: port and counter are absent and no counter logic is generated.

## Structure
- Shared package dawn_pkg holds the stat_t encoding (AOK/HLT/ADR/INS) and the REG_NONE constant.
- Sub-module wb_stat_enc is the combinational priority encoder from the four error/halt inputs plus m_valid_i to stat_t.

## Test plan
- Writeback: m_valE_i=0x11, dstE=3, m_valM_i=0x22, dstM=5, all flags clean → next cycle weE=1 (r3=0x11), weM=1 (r5=0x22), w_stat_o=AOK.
- Stall/bubble: w_stall_i=1 with new inputs → W outputs unchanged. w_stall_i=1 and w_bubble_i=1 → hold. w_bubble_i only → both enables 0.
- Halt: m_hlt_i=1 with dstE=2 → weE=0, w_stat_o=HLT. After the next edge cpu_stat_o=HLT, halted_o=1, and subsequent valid writes are suppressed.
- Error priority: m_imem_error_i=1 and m_instr_valid_i=0 → ADR. m_instr_valid_i=0 and m_hlt_i=1 → INS.
- Reset in STOP: assert rst_n_i=0 asynchronously → all outputs 0/AOK immediately. After release, normal writeback resumes.
- WB_RETIRE_CNT_EN: 5 clean instructions, 1 bubble, 1 stalled cycle → retire_cnt_o=5. Preload near 2^CNT_W−1 → wraps to 0.
